// File: rtl/sdram_aref_ctrl.sv
// SDRAM auto-refresh controller: tracks owed refreshes and, once granted,
// issues PRECHARGE-all followed by AUTO REFRESH until the debt is drained.
module sdram_aref_ctrl #(
   parameter int CNT_REF_MAX = 749,
   parameter int TRP_CLK     = 2,
   parameter int TRC_CLK     = 7,
   parameter int DEBT_MAX    = 8,
   parameter int ADDR_W      = 13,
   parameter int BA_W        = 2
) (
   input  logic              sys_clk,
   input  logic              sys_rst,
   input  logic              init_end,
   input  logic              aref_en,
   output logic              aref_req,
   output logic              aref_urgent,
   output logic [3:0]        aref_cmd,
   output logic [BA_W-1:0]   aref_ba,
   output logic [ADDR_W-1:0] aref_addr,
   output logic              aref_busy,
   output logic              aref_end,
   output logic [3:0]        debt_cnt,
   output logic              aref_ovf
);

   localparam int CNT_W  = (CNT_REF_MAX < 1) ? 1 : $clog2(CNT_REF_MAX + 1);
   localparam int WMAX   = (TRC_CLK > TRP_CLK) ? TRC_CLK : TRP_CLK;
   localparam int WAIT_W = ($clog2(WMAX + 1) < 3) ? 3 : $clog2(WMAX + 1);

   localparam logic [3:0] CMD_NOP  = 4'b0111;
   localparam logic [3:0] CMD_PRE  = 4'b0010;
   localparam logic [3:0] CMD_AREF = 4'b0001;

   typedef enum logic [2:0] {
      IDLE, PCHA, TRP, AREF, TRC, END
   } state_t;

   state_t             state;
   logic [CNT_W-1:0]   cnt_ref;
   logic [WAIT_W-1:0]  cnt_wait;
   logic               tick;
   logic               dec;

   assign tick = init_end && (cnt_ref == CNT_W'(CNT_REF_MAX));
   assign dec  = (state == AREF);

   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         cnt_ref <= '0;
      end else if (init_end) begin
         cnt_ref <= tick ? '0 : cnt_ref + CNT_W'(1);
      end
   end

   // A tick and a refresh in the same cycle cancel out.
   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         debt_cnt <= '0;
         aref_ovf <= 1'b0;
      end else if (tick && !dec) begin
         if (debt_cnt == 4'(DEBT_MAX))
            aref_ovf <= 1'b1;
         else
            debt_cnt <= debt_cnt + 4'd1;
      end else if (dec && !tick && debt_cnt != '0) begin
         debt_cnt <= debt_cnt - 4'd1;
      end
   end

   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         state    <= IDLE;
         cnt_wait <= '0;
         aref_cmd <= CMD_NOP;
      end else begin
         cnt_wait <= cnt_wait + WAIT_W'(1);
         unique case (state)
            IDLE: begin
               if (aref_en && init_end && debt_cnt != '0) begin
                  state    <= PCHA;
                  cnt_wait <= '0;
               end
            end
            PCHA: begin
               state    <= TRP;
               cnt_wait <= '0;
            end
            TRP: begin
               if (cnt_wait == WAIT_W'(TRP_CLK)) begin
                  state    <= AREF;
                  cnt_wait <= '0;
               end
            end
            AREF: begin
               state    <= TRC;
               cnt_wait <= '0;
            end
            // A tick landing on the last TRC cycle still gets served.
            TRC: begin
               if (cnt_wait == WAIT_W'(TRC_CLK)) begin
                  state    <= (debt_cnt != '0 || tick) ? AREF : END;
                  cnt_wait <= '0;
               end
            end
            END: begin
               state    <= IDLE;
               cnt_wait <= '0;
            end
            default: begin
               state    <= IDLE;
               cnt_wait <= '0;
            end
         endcase
         if (state == PCHA)
            aref_cmd <= CMD_PRE;
         else if (state == AREF)
            aref_cmd <= CMD_AREF;
         else
            aref_cmd <= CMD_NOP;
      end
   end

   assign aref_ba     = '1;
   assign aref_addr   = '1;
   assign aref_busy   = (state != IDLE);
   assign aref_end    = (state == END);
   assign aref_req    = (state == IDLE) && (debt_cnt != '0);
   assign aref_urgent = (debt_cnt >= 4'(DEBT_MAX - 1));

endmodule
